// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment encoder/decoder pair.
// Holds the segment pattern type, the hex glyph table, the blank pattern
// and the scan decoder FSM state encoding.
package seg_pkg;

    // Active-low segment pattern, {g,f,e,d,c,b,a}; bit 0 is segment a.
    typedef logic [6:0] seg_pattern_t;

    localparam seg_pattern_t SEG_BLANK = 7'b1111111;

    // Index is the hex nibble that the glyph represents.
    localparam seg_pattern_t SEG_HEX [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        LOCKED
    } scan_state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational reverse lookup of an active-low segment pattern.
// Ports: seg_i pattern in; hit_o = matches a hex glyph, nibble_o = that
// glyph's value (0 when no hit), is_blank_o = all segments off.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       hit_o,
    output logic       is_blank_o,
    output logic [3:0] nibble_o
);

    always_comb begin
        hit_o    = 1'b0;
        nibble_o = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == SEG_HEX[i]) begin
                hit_o    = 1'b1;
                nibble_o = 4'(i);
            end
        end
        is_blank_o = (seg_i == SEG_BLANK);
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers per-digit hex values from the pins of a scanned 7-segment display.
// Ports: clk_i/reset_i (async, active-high); seg_n_i, an_n_i display lines;
// err_clr_i clears code_err_o; value_o/digit_valid_o/blank_o per-digit state;
// update_o/update_idx_o one-cycle commit pulse and the digit it targeted.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int  DIGITS        = 4,
    parameter int  STABLE_CYCLES = 8,
    parameter int  SYNC_STAGES   = 2,
    localparam int IDXW          = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [6:0]            seg_n_i,
    input  logic [DIGITS-1:0]     an_n_i,
    input  logic                  err_clr_i,
    output logic [4*DIGITS-1:0]   value_o,
    output logic [DIGITS-1:0]     digit_valid_o,
    output logic [DIGITS-1:0]     blank_o,
    output logic                  code_err_o,
    output logic                  update_o,
    output logic [IDXW-1:0]       update_idx_o
);

    localparam int TW   = DIGITS + 7;
    localparam int CNTW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNTW-1:0] CNT_TARGET = CNTW'(STABLE_CYCLES);

    // ---------------- input synchronizer on the {an, seg} tuple ----------
    logic [TW-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
        end else begin
            sync_q[0] <= {an_n_i, seg_n_i};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    logic [TW-1:0]     tuple;
    logic [DIGITS-1:0] an_low;
    logic [6:0]        seg;
    logic              one_hot;
    logic [IDXW-1:0]   sel_idx;

    assign tuple   = sync_q[SYNC_STAGES-1];
    assign an_low  = ~tuple[TW-1:7];
    assign seg     = tuple[6:0];
    assign one_hot = (an_low != '0) && ((an_low & (an_low - 1'b1)) == '0);

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (an_low[i]) sel_idx = IDXW'(i);
        end
    end

    logic       dec_hit;
    logic       dec_blank;
    logic [3:0] dec_nib;

    seg_pattern_decode u_decode (
        .seg_i      (seg),
        .hit_o      (dec_hit),
        .is_blank_o (dec_blank),
        .nibble_o   (dec_nib)
    );

    // ---------------- stability tracking ----------------------------------
    scan_state_t       state_q;
    logic [CNTW-1:0]   cnt_q;
    logic [CNTW-1:0]   cnt_d;
    logic [TW-1:0]     held_q;
    logic              changed;
    logic              commit;

    assign changed = (tuple != held_q);

    always_comb begin
        cnt_d = cnt_q;
        if (!one_hot) begin
            cnt_d = '0;
        end else if (changed) begin
            cnt_d = CNTW'(1);
        end else if (state_q != LOCKED && cnt_q != CNT_TARGET) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // A locked, unchanged tuple never re-commits; everything else commits
    // on the cycle its run length hits the target.
    assign commit = one_hot && (changed || state_q != LOCKED) && (cnt_d == CNT_TARGET);

    // ---------------- FSM and registered outputs --------------------------
    logic [4*DIGITS-1:0] value_q;
    logic [DIGITS-1:0]   valid_q;
    logic [DIGITS-1:0]   blank_q;
    logic                err_q;
    logic                update_q;
    logic [IDXW-1:0]     idx_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            held_q   <= '1;
            value_q  <= '0;
            valid_q  <= '0;
            blank_q  <= '0;
            err_q    <= 1'b0;
            update_q <= 1'b0;
            idx_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            update_q <= commit;

            if (!one_hot)                          state_q <= IDLE;
            else if (commit)                       state_q <= LOCKED;
            else if (changed || state_q != LOCKED) state_q <= SETTLE;

            if (one_hot && changed) held_q <= tuple;

            // Clear first so a same-cycle error commit overrides it.
            if (err_clr_i) err_q <= 1'b0;

            if (commit) begin
                idx_q <= sel_idx;
                if (dec_hit) begin
                    value_q[{sel_idx, 2'b00} +: 4] <= dec_nib;
                    valid_q[sel_idx] <= 1'b1;
                    blank_q[sel_idx] <= 1'b0;
                end else if (dec_blank) begin
                    valid_q[sel_idx] <= 1'b0;
                    blank_q[sel_idx] <= 1'b1;
                end else begin
                    err_q            <= 1'b1;
                    valid_q[sel_idx] <= 1'b0;
                    blank_q[sel_idx] <= 1'b0;
                end
            end
        end
    end

    assign value_o       = value_q;
    assign digit_valid_o = valid_q;
    assign blank_o       = blank_q;
    assign code_err_o    = err_q;
    assign update_o      = update_q;
    assign update_idx_o  = idx_q;

endmodule
